// File: rtl/key_press_classifier.sv
// rtl/key_press_classifier.sv - classifies a debounced key into short, long and double-click strobes
// Registered one-cycle strobes; busy follows the registered FSM state.
module key_press_classifier #(
   parameter int LONG_TIME  = 50_000_000,
   parameter int DOUBLE_GAP = 12_500_000,
   parameter int CNT_W      = 26
) (
   input  logic clk,
   input  logic rst,
   input  logic key_in,
   output logic short_pulse,
   output logic long_pulse,
   output logic double_pulse,
   output logic busy
);

   typedef enum logic [2:0] {
      IDLE,
      PRESS1,
      WAIT2,
      PRESS2,
      LONG_HOLD
   } state_t;

   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TIME - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DOUBLE_GAP - 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               key_q, key_d;
   logic               short_q, short_d;
   logic               long_q, long_d;
   logic               double_q, double_d;
   logic               busy_q, busy_d;
   logic               press_edge, release_edge;

   // key level is active-low, so a press is a 1 -> 0 transition
   assign press_edge   = key_q & ~key_in;
   assign release_edge = ~key_q & key_in;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         key_q    <= 1'b0;
         short_q  <= 1'b0;
         long_q   <= 1'b0;
         double_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         key_q    <= key_d;
         short_q  <= short_d;
         long_q   <= long_d;
         double_q <= double_d;
         busy_q   <= busy_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      key_d    = key_in;
      short_d  = 1'b0;
      long_d   = 1'b0;
      double_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (press_edge) begin
               state_d = PRESS1;
               cnt_d   = '0;
            end
         end
         PRESS1: begin
            cnt_d = cnt_q + CNT_W'(1);
            // release takes priority over a coincident long threshold
            if (release_edge) begin
               state_d = WAIT2;
               cnt_d   = '0;
            end else if (cnt_q == LONG_LAST && !key_in) begin
               state_d = LONG_HOLD;
               long_d  = 1'b1;
               cnt_d   = '0;
            end
         end
         LONG_HOLD: begin
            if (release_edge) state_d = IDLE;
         end
         WAIT2: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (press_edge) begin
               state_d  = PRESS2;
               double_d = 1'b1;
               cnt_d    = '0;
            end else if (cnt_q == GAP_LAST) begin
               state_d = IDLE;
               short_d = 1'b1;
               cnt_d   = '0;
            end
         end
         PRESS2: begin
            if (release_edge) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   assign short_pulse  = short_q;
   assign long_pulse   = long_q;
   assign double_pulse = double_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_key_press_classifier.sv
// tb/tb_key_press_classifier.sv - scoreboard bench for key_press_classifier
// Expected strobes come from an event-level model working on press/release positions.
module tb_key_press_classifier;

   localparam int LT = 20;
   localparam int DG = 10;
   localparam int K_SHORT  = 0;
   localparam int K_LONG   = 1;
   localparam int K_DOUBLE = 2;

   typedef struct {
      int edge_no;
      int kind;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic key_in = 1'b1;
   logic short_pulse, long_pulse, double_pulse, busy;

   int   total = 0;
   int   bad = 0;
   int   cur_edge = -1;
   bit   seq[$];
   bit   busy_exp[$];
   ev_t  exp_q[$];

   key_press_classifier #(
      .LONG_TIME (LT),
      .DOUBLE_GAP(DG),
      .CNT_W     (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .key_in      (key_in),
      .short_pulse (short_pulse),
      .long_pulse  (long_pulse),
      .double_pulse(double_pulse),
      .busy        (busy)
   );

   always #10 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cur_edge);
      end
   endtask

   function automatic int next_press(input int from);
      bit prev;
      for (int i = from; i < seq.size(); i++) begin
         prev = (i == 0) ? 1'b0 : seq[i-1];
         if (prev && !seq[i]) return i;
      end
      return -1;
   endfunction

   function automatic int next_high(input int from);
      for (int i = from; i < seq.size(); i++)
         if (seq[i]) return i;
      return seq.size();
   endfunction

   task automatic add_ev(input int e, input int kind);
      ev_t ev;
      if (e < seq.size()) begin
         ev.edge_no = e;
         ev.kind    = kind;
         exp_q.push_back(ev);
      end
   endtask

   task automatic mark_busy(input int a, input int b);
      for (int i = a; i <= b && i < seq.size(); i++) busy_exp[i] = 1'b1;
   endtask

   // Walks the key sequence press by press, deciding each gesture from hold and gap lengths.
   task automatic build_model();
      int n, p1, r1, p2, r2;
      exp_q.delete();
      busy_exp.delete();
      for (int i = 0; i < seq.size(); i++) busy_exp.push_back(1'b0);
      n = 0;
      forever begin
         p1 = next_press(n);
         if (p1 < 0) break;
         r1 = next_high(p1 + 1);
         if (r1 > p1 + LT) begin
            add_ev(p1 + LT, K_LONG);
            mark_busy(p1, r1 - 1);
            n = r1 + 1;
         end else begin
            p2 = next_press(r1 + 1);
            if (p2 >= 0 && p2 <= r1 + DG) begin
               add_ev(p2, K_DOUBLE);
               r2 = next_high(p2 + 1);
               mark_busy(p1, r2 - 1);
               n = r2 + 1;
            end else begin
               add_ev(r1 + DG, K_SHORT);
               mark_busy(p1, r1 + DG - 1);
               n = r1 + DG + 1;
            end
         end
         if (n >= seq.size()) break;
      end
   endtask

   task automatic push(input bit v, input int count);
      for (int i = 0; i < count; i++) seq.push_back(v);
   endtask

   task automatic check_reset_outputs();
      check("rst_short", short_pulse, 0);
      check("rst_long", long_pulse, 0);
      check("rst_double", double_pulse, 0);
      check("rst_busy", busy, 0);
   endtask

   // Enters with rst high; leaves with rst high again after the sequence (or abort point).
   task automatic run(input bit init_level);
      build_model();
      key_in = init_level;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < seq.size(); n++) begin
         key_in = seq[n];
         @(posedge clk);
         cur_edge = n;
         @(negedge clk);
      end
      #2;
      rst = 1'b1;
      cur_edge = -1;
      #1;
      check_reset_outputs();
      check("missing_pulses", exp_q.size(), 0);
      exp_q.delete();
   endtask

   always @(negedge clk) begin
      int np, kind;
      ev_t ev;
      if (!rst && cur_edge >= 0) begin
         np = int'(short_pulse) + int'(long_pulse) + int'(double_pulse);
         check("single_strobe", int'(np <= 1), 1);
         if (np > 0) begin
            kind = long_pulse ? K_LONG : (double_pulse ? K_DOUBLE : K_SHORT);
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_pulse: got kind %0d at edge %0d, expected none", kind, cur_edge);
            end else begin
               ev = exp_q.pop_front();
               check("pulse_kind", kind, ev.kind);
               check("pulse_edge", cur_edge, ev.edge_no);
            end
         end
         check("busy", int'(busy), int'(busy_exp[cur_edge]));
      end
   end

   initial begin
      int nseg, cat;
      bit init;
      rst = 1'b1;
      key_in = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_outputs();

      // single short press
      seq.delete(); push(1, 2); push(0, 5); push(1, 40); run(1'b1);
      // long press held 100 cycles
      seq.delete(); push(1, 2); push(0, 100); push(1, 40); run(1'b1);
      // long threshold boundary: release coincident with threshold, then one beyond
      seq.delete(); push(1, 2); push(0, LT); push(1, 40); run(1'b1);
      seq.delete(); push(1, 2); push(0, LT + 1); push(1, 40); run(1'b1);
      // double click
      seq.delete(); push(1, 2); push(0, 4); push(1, 4); push(0, 4); push(1, 40); run(1'b1);
      // gap boundary around DOUBLE_GAP
      for (int g = DG - 1; g <= DG + 1; g++) begin
         seq.delete(); push(1, 2); push(0, 4); push(1, g); push(0, 4); push(1, 40); run(1'b1);
      end
      // third press after a double click
      seq.delete(); push(1, 2); push(0, 3); push(1, 3); push(0, 3); push(1, 3); push(0, 3); push(1, 40);
      run(1'b1);
      // key held low through reset release
      seq.delete(); push(0, 50); push(1, 40); run(1'b0);
      // reset during WAIT2
      seq.delete(); push(1, 2); push(0, 4); push(1, 5); run(1'b1);

      for (int r = 0; r < 40; r++) begin
         seq.delete();
         init = 1'($urandom_range(0, 1));
         push(init, $urandom_range(0, 3));
         nseg = $urandom_range(1, 5);
         for (int s = 0; s < nseg; s++) begin
            cat = $urandom_range(0, 3);
            case (cat)
               0: push(0, $urandom_range(1, 6));
               1: push(0, $urandom_range(LT - 3, LT + 3));
               2: push(0, $urandom_range(LT + 4, 2 * LT));
               default: push(0, $urandom_range(3, 10));
            endcase
            push(1, $urandom_range(1, DG + 4));
         end
         if ($urandom_range(0, 3) != 0) push(1, LT + DG + 5);
         run(init);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
